control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports Clock and clear.
REQ-002 Port Clock, input, 1, rising-edge clock for all state.
REQ-003 Port clear, input, 1, synchronous active-high reset.
REQ-004 Port run, input, 1, level; 1 permits fetch of next instruction.
REQ-005 Port IR, input, 32, instruction register contents: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
REQ-006 Ports PCout, MARin, IncPC, Zin_low, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin, output, 1 each, datapath strobes.
REQ-007 Port Rout, output, 16, one-hot register-to-bus select; Rout[n] drives Rn.
REQ-008 Port Rin, output, 16, one-hot register load select; Rin[n] loads Rn.
REQ-009 Port operation, output, 4, ALU function code.
REQ-010 Port done, output, 1, one-cycle pulse at end of each T5.
REQ-011 Port halted, output, 1, level; 1 while in HALT.
REQ-012 Port illegal, output, 1, one-cycle pulse on undefined opcode.

Function
REQ-013 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, HALT; one state per clock.
REQ-014 IDLE: all outputs 0; IDLE->T0 when run=1, else stay.
REQ-015 T0: PCout=1, MARin=1, IncPC=1, Zin_low=1; ->T1.
REQ-016 T1: Zlowout=1, PCin=1, Read=1, MDRin=1; ->T2.
REQ-017 T2: MDRout=1, IRin=1; ->T3.
REQ-018 Decode SHALL use IR as sampled in T3 and later; IR is stable from T3 onward.
REQ-019 T3: Rout[Rb]=1, Yin=1; ->T4 for legal ALU opcode; ->HALT for opcode 11011; ->T0 (run=1) or IDLE (run=0) with illegal=1 otherwise.
REQ-020 T4: Rout[Rc]=1 (two-operand ops) or all Rout 0 (neg), operation=code, Zin_low=1; ->T5.
REQ-021 T5: Zlowout=1, Rin[Ra]=1, done=1; ->T0 if run=1, else IDLE.
REQ-022 Opcode->operation: 00011 add->0011, 00100 sub->0100, 00101 and->1010, 00110 or->1011, 10001 neg->1111.
REQ-023 operation SHALL be 0000 in every state except T4.
REQ-024 Rout and Rin SHALL never have more than one bit set; all zero outside states in REQ-019..021.
REQ-025 Ra=0 SHALL still assert Rin[0] (R0 is an ordinary register).
REQ-026 Outputs SHALL be Moore (function of state and registered IR only); no combinational path from run to any strobe.
REQ-027 run deasserted mid-instruction SHALL not abort; current instruction completes through T5.
REQ-028 HALT: halted=1, all other outputs 0; leaves only on clear.
REQ-029 done and illegal SHALL each be high for exactly one cycle per event.

Reset
REQ-030 clear=1 at a rising edge SHALL force IDLE on that edge, from any state including mid-instruction and HALT.
REQ-031 After reset all outputs SHALL be 0, including halted, done, illegal, operation=0000.
REQ-032 clear SHALL take priority over run and every state transition.

Verification
REQ-033 run=1, IR=0x28918000 (and R1,R2,R3) -> T0..T5 in 6 cycles; T3 Rout=0x0004, Yin; T4 Rout=0x0008, operation=1010; T5 Rin=0x0002, done=1.
REQ-034 IR=0x88100000 (neg R0,R2) -> T3 Rout=0x0004; T4 Rout=0x0000, operation=1111; T5 Rin=0x0001.
REQ-035 IR opcode 11111 -> illegal=1 in T3, no Rin asserted, next state T0 (run=1).
REQ-036 IR opcode 11011 -> HALT, halted=1 held 20 cycles despite run=1; clear -> IDLE, halted=0.
REQ-037 clear asserted during T4 -> next cycle IDLE, all outputs 0, no Rin pulse issued.
REQ-038 run dropped during T2 -> instruction completes to T5 with done=1, then IDLE.

Source files
------------

// File: rtl/control_sequencer.sv
// Instruction sequencer for a single-bus datapath: fetch (T0-T2), register ALU execute
// (T3-T5), halt on opcode 11011. Strobes are a Moore decode of the state and the held IR.
//
// state | meaning
// IDLE  | waiting for run
// T0    | PC to MAR, PC increment into Z
// T1    | Z to PC, memory read into MDR
// T2    | MDR to IR
// T3    | Rb to Y, decode opcode
// T4    | Rc (or nothing for neg) through ALU into Z
// T5    | Z to Ra, instruction done
// HALT  | stopped until clear
module control_sequencer (
    input  logic        Clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin_low,
    output logic        Zlowout,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic [3:0]  operation,
    output logic        done,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T0   = 3'd1,
        T1   = 3'd2,
        T2   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5,
        T5   = 3'd6,
        HALT = 3'd7
    } state_t;

    localparam logic [4:0] OPC_HALT = 5'b11011;

    state_t     state;
    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic [3:0] alu_code;
    logic       alu_legal;
    logic       two_operand;

    assign opcode = IR[31:27];
    assign ra     = IR[26:23];
    assign rb     = IR[22:19];
    assign rc     = IR[18:15];

    always_comb begin
        alu_legal   = 1'b1;
        two_operand = 1'b1;
        alu_code    = 4'b0000;
        case (opcode)
            5'b00011: alu_code = 4'b0011;
            5'b00100: alu_code = 4'b0100;
            5'b00101: alu_code = 4'b1010;
            5'b00110: alu_code = 4'b1011;
            5'b10001: begin
                alu_code    = 4'b1111;
                two_operand = 1'b0;
            end
            default: alu_legal = 1'b0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (run) state <= T0;
                T0:   state <= T1;
                T1:   state <= T2;
                T2:   state <= T3;
                T3: begin
                    if (opcode == OPC_HALT) state <= HALT;
                    else if (alu_legal)     state <= T4;
                    else if (run)           state <= T0;
                    else                    state <= IDLE;
                end
                T4:   state <= T5;
                T5:   state <= run ? T0 : IDLE;
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    // IR is only consulted from T3 on, where it is guaranteed stable.
    always_comb begin
        PCout     = 1'b0;
        MARin     = 1'b0;
        IncPC     = 1'b0;
        Zin_low   = 1'b0;
        Zlowout   = 1'b0;
        PCin      = 1'b0;
        Read      = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Rout      = 16'h0000;
        Rin       = 16'h0000;
        operation = 4'b0000;
        done      = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;
        case (state)
            T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin_low = 1'b1;
            end
            T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                Rout[rb] = 1'b1;
                Yin      = 1'b1;
                illegal  = !alu_legal && (opcode != OPC_HALT);
            end
            T4: begin
                if (two_operand) Rout[rc] = 1'b1;
                operation = alu_code;
                Zin_low   = 1'b1;
            end
            T5: begin
                Zlowout = 1'b1;
                Rin[ra] = 1'b1;
                done    = 1'b1;
            end
            HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus a randomized run,
// each cycle compared against a cycle-count model of the instruction timing.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        clear, run;
    logic [31:0] IR;
    logic        PCout, MARin, IncPC, Zin_low, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic [15:0] Rout, Rin;
    logic [3:0]  operation;
    logic        done, halted, illegal;

    int compared   = 0;
    int mismatched = 0;

    // Model: mode 0 = idle, 1 = executing (step = cycles since fetch began), 2 = halted
    int m_mode = 0;
    int m_step = 0;
    int halt_cycles = 0;

    control_sequencer dut (
        .Clock(Clock), .clear(clear), .run(run), .IR(IR),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin_low(Zin_low),
        .Zlowout(Zlowout), .PCin(PCin), .Read(Read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Rout(Rout), .Rin(Rin),
        .operation(operation), .done(done), .halted(halted), .illegal(illegal)
    );

    always #5 Clock = ~Clock;

    // Packed view: {11 strobes, Rout, Rin, operation, done, halted, illegal}
    function automatic logic [49:0] actual();
        return {PCout, MARin, IncPC, Zin_low, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin,
                Rout, Rin, operation, done, halted, illegal};
    endfunction

    function automatic void spec_op(input logic [4:0] opc, output logic legal,
                                    output logic two, output logic [3:0] code);
        legal = 1'b1; two = 1'b1; code = 4'b0000;
        if      (opc == 5'b00011) code = 4'b0011;
        else if (opc == 5'b00100) code = 4'b0100;
        else if (opc == 5'b00101) code = 4'b1010;
        else if (opc == 5'b00110) code = 4'b1011;
        else if (opc == 5'b10001) begin code = 4'b1111; two = 1'b0; end
        else legal = 1'b0;
    endfunction

    function automatic logic [49:0] expected(input int mode, input int step, input logic [31:0] ir);
        logic [10:0] s;
        logic [15:0] ro, ri;
        logic [3:0]  op, code;
        logic        dn, hl, il, legal, two;
        s = '0; ro = '0; ri = '0; op = '0; dn = 0; hl = 0; il = 0;
        spec_op(ir[31:27], legal, two, code);
        if (mode == 2) hl = 1'b1;
        else if (mode == 1) begin
            if (step == 0) s = 11'b111_1000_0000;
            if (step == 1) s = 11'b000_0111_1000;
            if (step == 2) s = 11'b000_0000_0110;
            if (step == 3) begin
                s  = 11'b000_0000_0001;
                ro = 16'(1) << ir[22:19];
                il = !legal && (ir[31:27] != 5'b11011);
            end
            if (step == 4) begin
                s  = 11'b000_1000_0000;
                ro = two ? 16'(1) << ir[18:15] : 16'h0000;
                op = code;
            end
            if (step == 5) begin
                s  = 11'b000_0100_0000;
                ri = 16'(1) << ir[26:23];
                dn = 1'b1;
            end
        end
        return {s, ro, ri, op, dn, hl, il};
    endfunction

    // Advance one clock; model consumes the inputs present at the edge.
    task automatic tick(output logic [49:0] exp);
        logic legal, two;
        logic [3:0] code;
        @(posedge Clock);
        spec_op(IR[31:27], legal, two, code);
        if (clear) m_mode = 0;
        else if (m_mode == 0) begin
            if (run) begin m_mode = 1; m_step = 0; end
        end else if (m_mode == 1) begin
            if (m_step == 3 && IR[31:27] == 5'b11011) m_mode = 2;
            else if ((m_step == 3 && !legal) || m_step == 5) begin
                if (run) m_step = 0; else m_mode = 0;
            end else m_step = m_step + 1;
        end
        halt_cycles = (m_mode == 2) ? halt_cycles + 1 : 0;
        @(negedge Clock);
        exp = expected(m_mode, m_step, IR);
    endtask

    task automatic test_reset();
        logic [49:0] e;
        clear = 1; run = 1; IR = 32'h2891_8000;
        for (int i = 0; i < 3; i++) begin
            tick(e);
            compared++;
            if (actual() !== e) begin
                mismatched++;
                $display("FAIL reset: got %h required %h", actual(), e);
            end
        end
        clear = 0; run = 0;
        for (int i = 0; i < 2; i++) begin
            tick(e);
            compared++;
            if (actual() !== e) begin
                mismatched++;
                $display("FAIL idle_hold: got %h required %h", actual(), e);
            end
        end
    endtask

    task automatic test_instr(input string name, input logic [31:0] ir, input int ncyc);
        logic [49:0] e;
        IR = ir; run = 1;
        for (int i = 0; i < ncyc; i++) begin
            tick(e);
            compared++;
            if (actual() !== e) begin
                mismatched++;
                $display("FAIL %s cyc%0d: got %h required %h", name, i, actual(), e);
            end
        end
        run = 0;
        tick(e);
        compared++;
        if (actual() !== e) begin
            mismatched++;
            $display("FAIL %s tail: got %h required %h", name, actual(), e);
        end
    endtask

    task automatic test_and_literal();
        logic [49:0] e;
        IR = 32'h2891_8000; run = 1;
        for (int i = 0; i < 6; i++) begin
            tick(e);
            if (i == 3) begin
                compared++;
                if (Rout !== 16'h0004 || Yin !== 1'b1) begin
                    mismatched++;
                    $display("FAIL and_t3: got Rout=%h Yin=%b required 0004 1", Rout, Yin);
                end
            end
            if (i == 4) begin
                compared++;
                if (Rout !== 16'h0008 || operation !== 4'b1010) begin
                    mismatched++;
                    $display("FAIL and_t4: got Rout=%h op=%b required 0008 1010", Rout, operation);
                end
            end
            if (i == 5) begin
                compared++;
                if (Rin !== 16'h0002 || done !== 1'b1) begin
                    mismatched++;
                    $display("FAIL and_t5: got Rin=%h done=%b required 0002 1", Rin, done);
                end
            end
        end
        run = 0;
        tick(e);
        compared++;
        if (actual() !== e || done !== 1'b0) begin
            mismatched++;
            $display("FAIL and_idle: got %h required %h", actual(), e);
        end
    endtask

    task automatic test_halt();
        logic [49:0] e;
        IR = 32'hD800_0000; run = 1;
        for (int i = 0; i < 24; i++) begin
            tick(e);
            compared++;
            if (actual() !== e || (i >= 4 && halted !== 1'b1)) begin
                mismatched++;
                $display("FAIL halt cyc%0d: got %h required %h", i, actual(), e);
            end
        end
        clear = 1;
        tick(e);
        clear = 0; run = 0;
        compared++;
        if (actual() !== e || halted !== 1'b0) begin
            mismatched++;
            $display("FAIL halt_clear: got %h required %h", actual(), e);
        end
    endtask

    task automatic test_clear_mid();
        logic [49:0] e;
        IR = 32'h1A21_8000; run = 1;
        for (int i = 0; i < 5; i++) tick(e);
        clear = 1; run = 1;
        tick(e);
        compared++;
        if (actual() !== e || Rin !== 16'h0000 || actual() !== 50'd0) begin
            mismatched++;
            $display("FAIL clear_t4: got %h required %h", actual(), e);
        end
        clear = 0; run = 0;
        tick(e);
        compared++;
        if (actual() !== e) begin
            mismatched++;
            $display("FAIL clear_after: got %h required %h", actual(), e);
        end
    endtask

    task automatic test_run_drop();
        logic [49:0] e;
        IR = 32'h2191_0000; run = 1;
        for (int i = 0; i < 7; i++) begin
            tick(e);
            if (i == 2) run = 0;
            compared++;
            if (actual() !== e || (i == 5 && done !== 1'b1)) begin
                mismatched++;
                $display("FAIL run_drop cyc%0d: got %h required %h", i, actual(), e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [49:0] e;
        IR = 32'h1912_0000; run = 1;
        for (int i = 0; i < 14; i++) begin
            tick(e);
            if (i == 6) IR = 32'h3078_0000;
            compared++;
            if (actual() !== e) begin
                mismatched++;
                $display("FAIL b2b cyc%0d: got %h required %h", i, actual(), e);
            end
        end
        run = 0;
        for (int i = 0; i < 6; i++) tick(e);
    endtask

    function automatic logic [31:0] rand_ir();
        logic [4:0] opc;
        int r;
        r = $urandom_range(0, 19);
        if      (r < 3)  opc = 5'b00011;
        else if (r < 6)  opc = 5'b00100;
        else if (r < 9)  opc = 5'b00101;
        else if (r < 12) opc = 5'b00110;
        else if (r < 15) opc = 5'b10001;
        else if (r == 15) opc = 5'b11011;
        else opc = 5'($urandom);
        return {opc, 27'($urandom)};
    endfunction

    task automatic test_random();
        logic [49:0] e;
        for (int i = 0; i < 3000; i++) begin
            clear = ($urandom_range(0, 59) == 0) || (halt_cycles > 6);
            run   = ($urandom_range(0, 3) != 0);
            if (m_mode != 1 || m_step >= 5 || m_step <= 1) begin
                if (m_mode != 1 || m_step <= 1) IR = rand_ir();
            end
            tick(e);
            compared++;
            if (actual() !== e) begin
                mismatched++;
                $display("FAIL random cyc%0d: got %h required %h ir=%h", i, actual(), e, IR);
            end
        end
    endtask

    initial begin
        clear = 1; run = 0; IR = '0;
        test_reset();
        test_and_literal();
        test_instr("neg", 32'h8810_0000, 6);
        test_instr("illegal", 32'hF800_0000, 5);
        run = 0;
        begin
            logic [49:0] e;
            for (int i = 0; i < 6; i++) tick(e);
        end
        test_halt();
        test_clear_mid();
        test_run_drop();
        test_back_to_back();
        clear = 1;
        begin
            logic [49:0] e;
            tick(e);
        end
        clear = 0;
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
